// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream (16-bit word count, big-endian words, XOR checksum)
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR = 32'h00000000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic byte_valid,
  input  logic [7:0] byte_data,
  output logic byte_ready,
  output logic im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic cpu_hold,
  output logic done,
  output logic error,
  output logic [ADDR_WIDTH:0] words_loaded
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERR    = 3'd7;
  logic [2:0] state;
  logic [15:0] n;
  logic [23:0] word;
  logic [1:0] idx;
  logic [7:0] checksum;
  logic acc;
  logic [16:0] n_new;
  assign byte_ready = state == LEN_HI || state == LEN_LO || state == DATA || state == CHECK;
  assign acc = byte_valid && byte_ready;
  assign im_we = state == WRITE;
  assign done = state == DONE;
  assign error = state == ERR;
  assign cpu_hold = state != DONE;
  assign n_new = {1'b0, n[15:8], byte_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n <= '0;
      word <= '0;
      idx <= '0;
      checksum <= '0;
      words_loaded <= '0;
      im_addr <= '0;
      im_wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state <= LEN_HI;
          words_loaded <= '0;
          checksum <= '0;
          idx <= '0;
        end
        LEN_HI: if (acc) begin
          n[15:8] <= byte_data;
          state <= LEN_LO;
        end
        LEN_LO: if (acc) begin
          n[7:0] <= byte_data;
          idx <= '0;
          state <= (n_new == 17'd0 || n_new > 17'(1 << ADDR_WIDTH)) ? ERR : DATA;
        end
        DATA: if (acc) begin
          word <= {word[15:0], byte_data};
          checksum <= checksum ^ byte_data;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            im_wdata <= {word, byte_data};
            im_addr <= BASE_ADDR + 32'({words_loaded, 2'b00});
            state <= WRITE;
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 1'b1;
          state <= (17'(words_loaded) + 17'd1 < {1'b0, n}) ? DATA : CHECK;
        end
        CHECK: if (acc) state <= (byte_data == checksum) ? DONE : ERR;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams; expected writes go to a scoreboard checked by a write monitor
module tb_imem_loader;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic byte_valid = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, im_we, cpu_hold, done, error;
  logic [31:0] im_addr, im_wdata;
  logic [8:0] words_loaded;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0] stream[$];

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we) begin
      tests++;
      if (exp_addr.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", im_addr, im_wdata);
      end else begin
        logic [31:0] a, d;
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        if (im_addr !== a || im_wdata !== d || byte_ready !== 1'b0) begin
          fails++;
          $display("FAIL write: got addr %h data %h ready %b, required addr %h data %h ready 0",
                   im_addr, im_wdata, byte_ready, a, d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic send(input int gap, input int start_at);
    int i = 0;
    int cyc = 0;
    logic acc;
    while (i < stream.size() && cyc < 1000) begin
      byte_valid = (gap == 0) || ($urandom_range(0, 99) >= gap);
      byte_data = byte_valid ? stream[i] : 8'hFF;
      start = (i == start_at);
      @(negedge clk);
      acc = byte_valid && byte_ready;
      step();
      if (acc) i++;
      cyc++;
    end
    byte_valid = 0;
    start = 0;
    tests++;
    if (i < stream.size()) begin
      fails++;
      $display("FAIL send_timeout: got %0d bytes accepted, required %0d", i, stream.size());
    end
  endtask

  task automatic chk_status(input string name, input logic d, input logic e, input logic h, input int wl);
    chk({name, "_done"}, 32'(done), 32'(d));
    chk({name, "_error"}, 32'(error), 32'(e));
    chk({name, "_hold"}, 32'(cpu_hold), 32'(h));
    chk({name, "_words"}, 32'(words_loaded), 32'(wl));
    chk({name, "_pending"}, exp_addr.size(), 0);
  endtask

  initial begin
    step();
    step();
    rst = 0;
    chk("rst_hold", 32'(cpu_hold), 1);
    chk("rst_ready", 32'(byte_ready), 0);
    chk("rst_we", 32'(im_we), 0);
    chk("rst_addr", im_addr, 0);
    chk("rst_wdata", im_wdata, 0);
    chk_status("rst", 0, 0, 1, 0);

    // basic load
    expect_write(32'h0, 32'h20080005);
    expect_write(32'h4, 32'h8C090004);
    pulse_start();
    chk("len_hi_ready", 32'(byte_ready), 1);
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
    send(0, -1);
    chk_status("basic", 1, 0, 0, 2);
    chk("basic_ready", 32'(byte_ready), 0);

    // bad checksum, restarting from DONE
    expect_write(32'h0, 32'h20080005);
    expect_write(32'h4, 32'h8C090004);
    pulse_start();
    chk("restart_hold", 32'(cpu_hold), 1);
    chk("restart_done", 32'(done), 0);
    stream[10] = 8'hAD;
    send(0, -1);
    chk_status("badsum", 0, 1, 1, 2);

    // zero count
    pulse_start();
    stream = '{8'h00, 8'h00};
    send(0, -1);
    chk_status("zero_n", 0, 1, 1, 0);

    // count one beyond capacity
    pulse_start();
    stream = '{8'h01, 8'h01};
    send(0, -1);
    chk_status("big_n", 0, 1, 1, 0);

    // random gaps in byte_valid
    expect_write(32'h0, 32'h20080005);
    expect_write(32'h4, 32'h8C090004);
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
    send(50, -1);
    chk_status("gaps", 1, 0, 0, 2);

    // reset lands in the WRITE cycle of the first word
    expect_write(32'h0, 32'h20080005);
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
    send(0, -1);
    rst = 1;
    step();
    rst = 0;
    chk("midrst_ready", 32'(byte_ready), 0);
    chk_status("midrst", 0, 0, 1, 0);
    expect_write(32'h0, 32'h20080005);
    expect_write(32'h4, 32'h8C090004);
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
    send(0, -1);
    chk_status("after_rst", 1, 0, 0, 2);

    // start during DATA is ignored
    expect_write(32'h0, 32'h20080005);
    expect_write(32'h4, 32'h8C090004);
    pulse_start();
    send(0, 4);
    chk_status("start_in_data", 1, 0, 0, 2);

    // second, one-word load after DONE
    expect_write(32'h0, 32'h00000000);
    pulse_start();
    chk("reload_hold", 32'(cpu_hold), 1);
    chk("reload_done", 32'(done), 0);
    chk("reload_words", 32'(words_loaded), 0);
    stream = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(0, -1);
    chk_status("reload", 1, 0, 0, 1);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
